// File: rtl/pio_in_edge_irq.sv
// rtl/pio_in_edge_irq.sv - Avalon-MM input PIO with synchroniser, debounce, edge capture and level IRQ
module pio_in_edge_irq #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0,
  parameter int DEBOUNCE  = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int DB_LAST_I = (DEBOUNCE > 0) ? DEBOUNCE - 1 : 0;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_LAST_I);

  typedef enum logic {ST_INIT, ST_PRIMED} prime_e;

  prime_e           prime_q, prime_d;
  logic [1:0]       prime_cnt_q, prime_cnt_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] rise, fall, edge_v, w1c;
  logic             wr;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  always_comb begin
    prime_d     = prime_q;
    prime_cnt_d = prime_cnt_q;
    if (prime_q == ST_INIT) begin
      if (prime_cnt_q == 2'd2) prime_d = ST_PRIMED;
      else                     prime_cnt_d = prime_cnt_q + 2'd1;
    end
  end

  // INIT loads the synchronised inputs straight into state so held-high pins start settled.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
    if (prime_q == ST_INIT || DEBOUNCE == 0) begin
      state_d = s2_q;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2_q[i] != state_q[i]) begin
          if (cnt_q[i] == DB_LAST) state_d[i] = s2_q[i];
          else                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // state_q is the previous debounced value of state_d, so edges land with the state change.
  always_comb begin
    rise   = ~state_q & state_d;
    fall   = state_q & ~state_d;
    edge_v = '0;
    if (prime_q == ST_PRIMED) begin
      if (EDGE_TYPE == 0)      edge_v = rise;
      else if (EDGE_TYPE == 1) edge_v = fall;
      else                     edge_v = rise | fall;
    end
  end

  assign wr = chipselect & ~write_n;

  always_comb begin
    irqmask_d  = irqmask_q;
    w1c        = '0;
    readdata_d = '0;
    if (wr && address == 2'd2) irqmask_d = writedata[WIDTH-1:0];
    if (wr && address == 2'd3) w1c = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~w1c) | edge_v;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = state_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prime_q     <= ST_INIT;
      prime_cnt_q <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      state_q     <= '0;
      irqmask_q   <= '0;
      edgecap_q   <= '0;
      readdata_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      prime_q     <= prime_d;
      prime_cnt_q <= prime_cnt_d;
      s1_q        <= in_port;
      s2_q        <= s1_q;
      state_q     <= state_d;
      irqmask_q   <= irqmask_d;
      edgecap_q   <= edgecap_d;
      readdata_q  <= readdata_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb/tb_pio_in_edge_irq.sv - scoreboard bench for pio_in_edge_irq across three parameter sets
module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [7:0]  in0, in1, in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got, want;

  always #5 clk = ~clk;

  // u0: rising, no debounce; u1: rising, debounce 4; u2: any edge, no debounce
  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE(0), .CNT_W(16)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE(4), .CNT_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));
  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE(0), .CNT_W(16)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input int dut, input logic [1:0] a, output logic [31:0] r);
    address = a;
    tick(1);
    r = (dut == 0) ? rd0 : (dut == 1) ? rd1 : rd2;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    in0 = 8'hA5; in1 = 8'h00; in2 = 8'h00;
    tick(3);
    exp_q.push_back(32'h0); want = exp_q.pop_front(); checks++;
    if (rd0 !== want) begin errors++; $display("FAIL reset_readdata got %h expected %h", rd0, want); end
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL reset_irq got %b expected 0", irq0); end
    reset_n = 1'b1;
    exp_q.push_back(32'h0);
    tick(3);
    want = exp_q.pop_front(); checks++;
    if (rd0 !== want) begin errors++; $display("FAIL data_cycle3 got %h expected %h", rd0, want); end
    exp_q.push_back(32'hA5);
    tick(1);
    want = exp_q.pop_front(); checks++;
    if (rd0 !== want) begin errors++; $display("FAIL data_cycle4 got %h expected %h", rd0, want); end
    exp_q.push_back(32'h0);
    bus_read(0, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL no_spurious_edge got %h expected %h", got, want); end
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL post_reset_irq got %b expected 0", irq0); end
  endtask

  task automatic test_rising_edge;
    bus_write(2'd2, 32'h01);
    in0 = 8'hA4;
    tick(5);
    exp_q.push_back(32'h0);
    bus_read(0, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL fall_ignored got %h expected %h", got, want); end
    in0 = 8'hA5;
    tick(2);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_early got %b expected 0", irq0); end
    tick(1);
    checks++;
    if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_cycle3 got %b expected 1", irq0); end
    exp_q.push_back(32'h01);
    bus_read(0, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL edgecap_rise got %h expected %h", got, want); end
    in0 = 8'hA4;
    tick(5);
    exp_q.push_back(32'h01);
    bus_read(0, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL edgecap_after_fall got %h expected %h", got, want); end
    bus_write(2'd3, 32'h01);
    checks++;
    if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_after_w1c got %b expected 0", irq0); end
    exp_q.push_back(32'h0);
    bus_read(0, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL edgecap_w1c got %h expected %h", got, want); end
  endtask

  task automatic test_debounce;
    in1[2] = 1'b1;
    tick(3);
    in1[2] = 1'b0;
    tick(10);
    exp_q.push_back(32'h0);
    bus_read(1, 2'd0, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL glitch_data got %h expected %h", got, want); end
    exp_q.push_back(32'h0);
    bus_read(1, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL glitch_edge got %h expected %h", got, want); end
    address = 2'd0;
    tick(1);
    in1[2] = 1'b1;
    // readdata after tick k shows state after edge k-1; state must flip at edge 6
    for (int k = 1; k <= 7; k++) begin
      exp_q.push_back((k >= 7) ? 32'h04 : 32'h0);
      tick(1);
      want = exp_q.pop_front(); checks++;
      if (rd1 !== want) begin errors++; $display("FAIL debounce_k%0d got %h expected %h", k, rd1, want); end
    end
    tick(3);
    in1[2] = 1'b0;
    tick(8);
    exp_q.push_back(32'h04);
    bus_read(1, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL debounce_edgecap got %h expected %h", got, want); end
  endtask

  task automatic test_set_clear_collision;
    in0 = 8'hA6;
    tick(2);
    bus_write(2'd3, 32'h02);
    exp_q.push_back(32'h02);
    bus_read(0, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL set_wins got %h expected %h", got, want); end
    bus_write(2'd3, 32'h02);
    exp_q.push_back(32'h0);
    bus_read(0, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL collision_clear got %h expected %h", got, want); end
  endtask

  task automatic test_any_edge;
    in2 = 8'h80;
    tick(5);
    exp_q.push_back(32'h80);
    bus_read(2, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL any_rise got %h expected %h", got, want); end
    checks++;
    if (irq2 !== 1'b0) begin errors++; $display("FAIL masked_irq got %b expected 0", irq2); end
    bus_write(2'd3, 32'h80);
    in2 = 8'h00;
    tick(5);
    exp_q.push_back(32'h80);
    bus_read(2, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL any_fall got %h expected %h", got, want); end
    bus_write(2'd2, 32'h80);
    checks++;
    if (irq2 !== 1'b1) begin errors++; $display("FAIL unmask_irq got %b expected 1", irq2); end
    bus_write(2'd0, 32'hFF);
    exp_q.push_back(32'h0);
    bus_read(2, 2'd0, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL data_ro got %h expected %h", got, want); end
    bus_write(2'd1, 32'hFF);
    exp_q.push_back(32'h0);
    bus_read(2, 2'd1, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL addr1_zero got %h expected %h", got, want); end
  endtask

  task automatic test_mid_reset;
    in2 = 8'hFF;
    tick(5);
    bus_write(2'd2, 32'hFF);
    exp_q.push_back(32'hFF);
    bus_read(2, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL pre_reset_edgecap got %h expected %h", got, want); end
    checks++;
    if (irq2 !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b expected 1", irq2); end
    in1 = 8'hF0;
    tick(4);
    address = 2'd3;
    reset_n = 1'b0;
    exp_q.push_back(32'h0);
    tick(1);
    reset_n = 1'b1;
    want = exp_q.pop_front(); checks++;
    if (rd2 !== want) begin errors++; $display("FAIL reset_rd got %h expected %h", rd2, want); end
    checks++;
    if ({irq0, irq1, irq2} !== 3'b000) begin errors++; $display("FAIL reset_irqs got %b expected 000", {irq0, irq1, irq2}); end
    exp_q.push_back(32'h0);
    bus_read(2, 2'd2, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_mask got %h expected %h", got, want); end
    tick(2);
    exp_q.push_back(32'hF0);
    bus_read(1, 2'd0, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_debounce_data got %h expected %h", got, want); end
    exp_q.push_back(32'h0);
    bus_read(2, 2'd3, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_no_spurious got %h expected %h", got, want); end
    exp_q.push_back(32'hFF);
    bus_read(2, 2'd0, got);
    want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_data_u2 got %h expected %h", got, want); end
  endtask

  initial begin
    test_reset;
    test_rising_edge;
    test_debounce;
    test_set_clear_collision;
    test_any_edge;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
